fb_port_scheduler: RTL and testbench
====================================

Name: fb_port_scheduler

Overview:
- Arbitrates the single frame-buffer memory command port between the VGA display line prefetcher (read) and two write requesters: camera ingest (WR0) and processed-video writeback (WR1).
- Issues fixed-length bursts and generates all memory addresses.
- Display fetch has strict priority; the write ports share the remaining bandwidth round-robin.
- Sits between the VGA controller's line-request logic and the memory controller.

Parameters:
H_ACT, 640, active pixels (words) per line
V_ACT, 480, active lines per frame
BURST, 128, words per burst; H_ACT and H_ACT*V_ACT are multiples of it
ADDR_W, 22, memory word-address width
DISP_BASE, 22'h000000, base of display read buffer
WR0_BASE, 22'h100000, base of camera write buffer
WR1_BASE, 22'h000000, base of processed write buffer

Ports:
iCLK  in  1  clock
iRST  in  1  asynchronous active-high reset
iEnable  in  1  0 = no new grants; an in-flight burst still completes
iDisp_Req  in  1  one-cycle pulse: fetch one line
iDisp_Line  in  11  line number, sampled with iDisp_Req
iWr0_Level  in  10  WR0 FIFO occupancy in words
iWr1_Level  in  10  WR1 FIFO occupancy in words
iWr0_Frame_Start  in  1  pulse: WR0 offset restarts at 0
iWr1_Frame_Start  in  1  pulse: WR1 offset restarts at 0
oMem_Cmd_Valid  out  1  command valid
iMem_Cmd_Ready  in  1  command accepted when Valid && Ready
oMem_Wr  out  1  1 = write burst, 0 = read burst
oMem_Addr  out  ADDR_W  burst start address
iMem_Done  in  1  pulse: accepted burst has fully transferred
oOwner  out  2  0 none, 1 display, 2 WR0, 3 WR1 (owner of current command/burst)
oDisp_Burst_Done  out  1  pulse per completed display burst
oWr0_Ack  out  1  pulse: one WR0 burst drained (BURST words)
oWr1_Ack  out  1  pulse: one WR1 burst drained
oDisp_Underrun  out  1  sticky; cleared only by reset

Behaviour:
- FSM has three states: IDLE, CMD, WAIT.
- IDLE: if iEnable and any requester is eligible, latch winner, address and oMem_Wr; go to CMD. First Cmd_Valid appears the cycle after eligibility is seen.
- CMD: oMem_Cmd_Valid=1; Addr, Wr and Owner held stable until Valid && Ready, then go to WAIT. iMem_Done in CMD is ignored.
- WAIT: Valid=0. On iMem_Done, pulse the owner's ack/done output for 1 cycle, update counters, go to IDLE. Minimum 1 idle cycle between bursts.
- Eligibility:
  - Display is eligible while line pending.
  - WRn is eligible when iWrn_Level >= BURST.
- Priority: display first. Between WR0 and WR1, a round-robin pointer (reset = WR0) picks one when both are eligible. The pointer moves to the other port after each write grant; display grants do not move it.
- Display pending:
  - iDisp_Req with iDisp_Line < V_ACT latches the line, sets idx=0 and pending=1.
  - iDisp_Req with iDisp_Line >= V_ACT is ignored.
  - Read address = DISP_BASE + line*H_ACT + idx*BURST, computed mod 2^ADDR_W.
  - Each display completion increments idx. At idx == H_ACT/BURST (5 by default), pending clears.
- Underrun: iDisp_Req arriving while pending=1:
  - Sets oDisp_Underrun and re-latches the line with idx=0.
  - A display burst already issued for the old line still completes, but its oDisp_Burst_Done is suppressed and idx is not incremented (per-burst stale tag).
  - A request arriving in the same cycle as the final completion is not an underrun.
- Write address = WRn_BASE + offset. After each WRn completion, offset += BURST. When the new value reaches H_ACT*V_ACT it wraps to 0.
- iWrn_Frame_Start sets offset=0. If it coincides with or precedes completion of an in-flight WRn burst, offset ends at 0 (no increment).
- Reset: all outputs 0 except oMem_Addr=0. FSM IDLE, pending=0, idx=0, offsets=0, RR pointer=WR0, underrun=0. Reset mid-burst abandons it; the memory side must also be reset.

Test Plan:
- Reset, then iDisp_Req with line 2, Ready tied 1, Done 4 cycles after acceptance:
  - Five reads at addresses 1280, 1408, 1536, 1664, 1792.
  - oOwner=1 throughout; five oDisp_Burst_Done pulses; then idle.
- iWr0_Level=iWr1_Level=200 held, no display:
  - Grants alternate WR0, WR1, WR0.
  - Addresses 0x100000, 0x000000, 0x100080; oMem_Wr=1; acks alternate.
- WR0 write in WAIT when iDisp_Req with line 0 arrives:
  - WR0 burst completes.
  - Next grant is display (addr 0) even though WR1 is eligible.
- iDisp_Req with line 10 during line 9's third in-flight burst:
  - oDisp_Underrun=1.
  - In-flight completion gives no done pulse.
  - Next read address is 6400.
- WR1 offset at 307072 completes a burst: wraps, next WR1 address 0x000000.
  - Frame_Start pulsed during a WAIT: next WR1 address is base.
- iEnable=0 with all requesters eligible: Valid stays 0; raising iEnable gives Valid one cycle later.
  - Also: assert iRST mid-CMD; all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/fb_port_scheduler.sv
// Frame-buffer command-port scheduler: strict-priority display line fetch,
// round-robin sharing of the remaining bursts between two write streams.
module fb_port_scheduler #(
    parameter int                H_ACT     = 640,
    parameter int                V_ACT     = 480,
    parameter int                BURST     = 128,
    parameter int                ADDR_W    = 22,
    parameter logic [ADDR_W-1:0] DISP_BASE = 22'h000000,
    parameter logic [ADDR_W-1:0] WR0_BASE  = 22'h100000,
    parameter logic [ADDR_W-1:0] WR1_BASE  = 22'h000000
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iEnable,
    input  logic              iDisp_Req,
    input  logic [10:0]       iDisp_Line,
    input  logic [9:0]        iWr0_Level,
    input  logic [9:0]        iWr1_Level,
    input  logic              iWr0_Frame_Start,
    input  logic              iWr1_Frame_Start,
    output logic              oMem_Cmd_Valid,
    input  logic              iMem_Cmd_Ready,
    output logic              oMem_Wr,
    output logic [ADDR_W-1:0] oMem_Addr,
    input  logic              iMem_Done,
    output logic [1:0]        oOwner,
    output logic              oDisp_Burst_Done,
    output logic              oWr0_Ack,
    output logic              oWr1_Ack,
    output logic              oDisp_Underrun
);

    localparam int NB          = H_ACT / BURST;
    localparam int IDX_W       = $clog2(NB + 1);
    localparam int FRAME_WORDS = H_ACT * V_ACT;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_DISP = 2'd1;
    localparam logic [1:0] OWN_WR0  = 2'd2;
    localparam logic [1:0] OWN_WR1  = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT} state_t;

    state_t            state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic              rr_q, rr_d;
    logic              pend_q, pend_d;
    logic [10:0]       line_q, line_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              stale_q, stale_d;
    logic              underrun_q, underrun_d;
    logic              disp_done_q, disp_done_d;

    logic [1:0]        grant_owner;
    logic              grant_valid;
    logic              done_evt;
    logic              req_ok;
    logic              disp_cmp;
    logic              disp_live;
    logic              final_cmp;
    logic              underrun_evt;
    logic              disp_inflight;
    logic [ADDR_W-1:0] disp_addr;

    logic [1:0]             wr_elig;
    logic [1:0]             wr_ack;
    logic [1:0]             wr_fs;
    logic [1:0][9:0]        wr_level;
    logic [1:0][ADDR_W-1:0] wr_off;

    assign wr_level[0] = iWr0_Level;
    assign wr_level[1] = iWr1_Level;
    assign wr_fs[0]    = iWr0_Frame_Start;
    assign wr_fs[1]    = iWr1_Frame_Start;

    // ---------------- state register ----------------
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_NONE;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            rr_q        <= 1'b0;
            pend_q      <= 1'b0;
            line_q      <= '0;
            idx_q       <= '0;
            stale_q     <= 1'b0;
            underrun_q  <= 1'b0;
            disp_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            rr_q        <= rr_d;
            pend_q      <= pend_d;
            line_q      <= line_d;
            idx_q       <= idx_d;
            stale_q     <= stale_d;
            underrun_q  <= underrun_d;
            disp_done_q <= disp_done_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant_valid)    state_d = S_CMD;
            S_CMD:   if (iMem_Cmd_Ready) state_d = S_WAIT;
            S_WAIT:  if (iMem_Done)      state_d = S_IDLE;
            default:                     state_d = S_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        oMem_Cmd_Valid   = (state_q == S_CMD);
        oOwner           = (state_q == S_IDLE) ? OWN_NONE : owner_q;
        oMem_Wr          = wr_q;
        oMem_Addr        = addr_q;
        oDisp_Burst_Done = disp_done_q;
        oWr0_Ack         = wr_ack[0];
        oWr1_Ack         = wr_ack[1];
        oDisp_Underrun   = underrun_q;
    end

    // ---------------- arbitration ----------------
    always_comb begin
        grant_owner = OWN_NONE;
        if ((state_q == S_IDLE) && iEnable) begin
            if (pend_q)
                grant_owner = OWN_DISP;
            else if (wr_elig[0] && wr_elig[1])
                grant_owner = rr_q ? OWN_WR1 : OWN_WR0;
            else if (wr_elig[0])
                grant_owner = OWN_WR0;
            else if (wr_elig[1])
                grant_owner = OWN_WR1;
        end
        grant_valid = (grant_owner != OWN_NONE);
    end

    always_comb begin
        disp_addr = DISP_BASE
                  + ADDR_W'(line_q) * ADDR_W'(H_ACT)
                  + ADDR_W'(idx_q)  * ADDR_W'(BURST);
        done_evt     = (state_q == S_WAIT) && iMem_Done;
        req_ok       = iDisp_Req && (32'(iDisp_Line) < V_ACT);
        disp_cmp     = done_evt && (owner_q == OWN_DISP);
        disp_live    = disp_cmp && !stale_q;
        final_cmp    = disp_live && (idx_q == IDX_W'(NB - 1));
        underrun_evt = req_ok && pend_q && !final_cmp;
        // a display burst that will still complete after this edge
        disp_inflight = ((state_q == S_CMD) && (owner_q == OWN_DISP))
                     || ((state_q == S_WAIT) && (owner_q == OWN_DISP) && !iMem_Done)
                     || (grant_owner == OWN_DISP);
    end

    // ---------------- command latch and display bookkeeping ----------------
    always_comb begin
        owner_d     = owner_q;
        addr_d      = addr_q;
        wr_d        = wr_q;
        rr_d        = rr_q;
        pend_d      = pend_q;
        line_d      = line_q;
        idx_d       = idx_q;
        stale_d     = stale_q;
        underrun_d  = underrun_q | underrun_evt;
        disp_done_d = 1'b0;

        if (grant_valid) begin
            owner_d = grant_owner;
            wr_d    = (grant_owner != OWN_DISP);
            case (grant_owner)
                OWN_DISP: addr_d = disp_addr;
                OWN_WR0:  addr_d = WR0_BASE + wr_off[0];
                default:  addr_d = WR1_BASE + wr_off[1];
            endcase
            if (grant_owner == OWN_WR0) rr_d = 1'b1;
            if (grant_owner == OWN_WR1) rr_d = 1'b0;
            if (grant_owner == OWN_DISP) stale_d = 1'b0;
        end

        if (disp_cmp) begin
            stale_d = 1'b0;
            // completion racing a re-request belongs to the abandoned line
            if (disp_live && !underrun_evt) begin
                disp_done_d = 1'b1;
                if (idx_q == IDX_W'(NB - 1)) begin
                    idx_d  = '0;
                    pend_d = 1'b0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
        end

        if (req_ok) begin
            line_d = iDisp_Line;
            idx_d  = '0;
            pend_d = 1'b1;
            if (disp_inflight) stale_d = 1'b1;
        end
    end

    // ---------------- per-write-port offset tracking ----------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_wr
            localparam logic [1:0] OWN_CODE = (gi == 0) ? OWN_WR0 : OWN_WR1;

            logic [ADDR_W-1:0] off_q, off_d, off_inc;
            logic              fs_q, fs_d;
            logic              ack_q, ack_d;
            logic              cmp, busy;

            assign wr_elig[gi] = (32'(wr_level[gi]) >= BURST);
            assign wr_off[gi]  = off_q;
            assign wr_ack[gi]  = ack_q;

            always_comb begin
                cmp     = done_evt && (owner_q == OWN_CODE);
                busy    = ((state_q != S_IDLE) && (owner_q == OWN_CODE))
                       || (grant_owner == OWN_CODE);
                off_inc = off_q + ADDR_W'(BURST);
                off_d   = off_q;
                fs_d    = fs_q;
                ack_d   = 1'b0;
                if (cmp) begin
                    ack_d = 1'b1;
                    fs_d  = 1'b0;
                    if (fs_q || wr_fs[gi] || (off_inc == ADDR_W'(FRAME_WORDS)))
                        off_d = '0;
                    else
                        off_d = off_inc;
                end else if (wr_fs[gi]) begin
                    off_d = '0;
                    // remember so the burst still in flight does not advance it
                    fs_d  = busy;
                end
            end

            always_ff @(posedge iCLK or posedge iRST) begin
                if (iRST) begin
                    off_q <= '0;
                    fs_q  <= 1'b0;
                    ack_q <= 1'b0;
                end else begin
                    off_q <= off_d;
                    fs_q  <= fs_d;
                    ack_q <= ack_d;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fb_port_scheduler.sv
// Directed bench for fb_port_scheduler: display fetch, write round-robin,
// priority, underrun, offset wrap / frame start, enable gating and reset.
module tb_fb_port_scheduler;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iEnable;
    logic        iDisp_Req;
    logic [10:0] iDisp_Line;
    logic [9:0]  iWr0_Level;
    logic [9:0]  iWr1_Level;
    logic        iWr0_Frame_Start;
    logic        iWr1_Frame_Start;
    logic        oMem_Cmd_Valid;
    logic        iMem_Cmd_Ready;
    logic        oMem_Wr;
    logic [21:0] oMem_Addr;
    logic        iMem_Done;
    logic [1:0]  oOwner;
    logic        oDisp_Burst_Done;
    logic        oWr0_Ack;
    logic        oWr1_Ack;
    logic        oDisp_Underrun;

    int checks = 0;
    int errors = 0;

    always #5 iCLK = ~iCLK;

    fb_port_scheduler dut (
        .iCLK             (iCLK),
        .iRST             (iRST),
        .iEnable          (iEnable),
        .iDisp_Req        (iDisp_Req),
        .iDisp_Line       (iDisp_Line),
        .iWr0_Level       (iWr0_Level),
        .iWr1_Level       (iWr1_Level),
        .iWr0_Frame_Start (iWr0_Frame_Start),
        .iWr1_Frame_Start (iWr1_Frame_Start),
        .oMem_Cmd_Valid   (oMem_Cmd_Valid),
        .iMem_Cmd_Ready   (iMem_Cmd_Ready),
        .oMem_Wr          (oMem_Wr),
        .oMem_Addr        (oMem_Addr),
        .iMem_Done        (iMem_Done),
        .oOwner           (oOwner),
        .oDisp_Burst_Done (oDisp_Burst_Done),
        .oWr0_Ack         (oWr0_Ack),
        .oWr1_Ack         (oWr1_Ack),
        .oDisp_Underrun   (oDisp_Underrun)
    );

    // Stimulus helpers: they only drive and capture, the tests compare.
    task automatic wait_cmd(output logic ok, output logic [21:0] addr,
                            output logic wr, output logic [1:0] own);
        ok = 1'b0; addr = '0; wr = 1'b0; own = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge iCLK);
            if (oMem_Cmd_Valid) begin
                ok = 1'b1; addr = oMem_Addr; wr = oMem_Wr; own = oOwner;
                break;
            end
        end
    endtask

    task automatic finish_burst(input int dly, output logic dd,
                                output logic a0, output logic a1);
        repeat (dly) @(negedge iCLK);
        iMem_Done = 1'b1;
        @(negedge iCLK);
        iMem_Done = 1'b0;
        dd = oDisp_Burst_Done; a0 = oWr0_Ack; a1 = oWr1_Ack;
    endtask

    task automatic pulse_disp(input logic [10:0] line);
        @(negedge iCLK);
        iDisp_Req = 1'b1; iDisp_Line = line;
        @(negedge iCLK);
        iDisp_Req = 1'b0;
    endtask

    task automatic count_valid(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge iCLK);
            if (oMem_Cmd_Valid) cnt++;
        end
    endtask

    task automatic test_reset;
        iRST = 1'b1; iEnable = 1'b1; iDisp_Req = 1'b0; iDisp_Line = '0;
        iWr0_Level = '0; iWr1_Level = '0; iWr0_Frame_Start = 1'b0;
        iWr1_Frame_Start = 1'b0; iMem_Cmd_Ready = 1'b1; iMem_Done = 1'b0;
        repeat (3) @(negedge iCLK);
        checks++;
        if ({oMem_Cmd_Valid, oMem_Wr, oOwner, oDisp_Burst_Done, oWr0_Ack, oWr1_Ack, oDisp_Underrun} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {oMem_Cmd_Valid, oMem_Wr, oOwner, oDisp_Burst_Done, oWr0_Ack, oWr1_Ack, oDisp_Underrun});
        end
        checks++;
        if (oMem_Addr !== 22'h0) begin
            errors++; $display("FAIL reset_addr: got %h want 000000", oMem_Addr);
        end
        iRST = 1'b0;
    endtask

    task automatic test_display_line;
        logic ok, w, dd, a0, a1; logic [21:0] a; logic [1:0] o; int cnt;
        pulse_disp(11'd480);
        count_valid(20, cnt);
        checks++;
        if (cnt !== 0) begin errors++; $display("FAIL line_oob_ignored: got %0d valids want 0", cnt); end
        pulse_disp(11'd2);
        for (int k = 0; k < 5; k++) begin
            wait_cmd(ok, a, w, o);
            $display("txn disp burst %0d addr=%0d wr=%0d owner=%0d", k, a, w, o);
            checks++;
            if (ok !== 1'b1) begin errors++; $display("FAIL disp_valid_timeout: burst %0d got no Valid want Valid", k); end
            checks++;
            if (a !== 22'(1280 + 128 * k)) begin errors++; $display("FAIL disp_addr: burst %0d got %0d want %0d", k, a, 1280 + 128 * k); end
            checks++;
            if ({w, o} !== 3'b001) begin errors++; $display("FAIL disp_wr_owner: got wr=%0d owner=%0d want wr=0 owner=1", w, o); end
            @(negedge iCLK);
            checks++;
            if (oOwner !== 2'd1) begin errors++; $display("FAIL disp_owner_wait: got %0d want 1", oOwner); end
            finish_burst(3, dd, a0, a1);
            checks++;
            if ({dd, a0, a1} !== 3'b100) begin errors++; $display("FAIL disp_done: got done/ack0/ack1=%b want 100", {dd, a0, a1}); end
        end
        count_valid(10, cnt);
        checks++;
        if (cnt !== 0) begin errors++; $display("FAIL disp_then_idle: got %0d valids want 0", cnt); end
    endtask

    task automatic test_write_rr;
        logic ok, w, dd, a0, a1; logic [21:0] a; logic [1:0] o;
        logic [21:0] exp_a [3];
        logic [1:0]  exp_o [3];
        exp_a[0] = 22'h100000; exp_a[1] = 22'h000000; exp_a[2] = 22'h100080;
        exp_o[0] = 2'd2; exp_o[1] = 2'd3; exp_o[2] = 2'd2;
        iWr0_Level = 10'd200; iWr1_Level = 10'd200;
        for (int k = 0; k < 3; k++) begin
            wait_cmd(ok, a, w, o);
            $display("txn write %0d addr=%h wr=%0d owner=%0d", k, a, w, o);
            if (k == 2) begin iWr0_Level = '0; iWr1_Level = '0; end
            checks++;
            if ({ok, a, w, o} !== {1'b1, exp_a[k], 1'b1, exp_o[k]}) begin
                errors++;
                $display("FAIL wr_rr_cmd: grant %0d got ok=%0d addr=%h wr=%0d owner=%0d want ok=1 addr=%h wr=1 owner=%0d",
                         k, ok, a, w, o, exp_a[k], exp_o[k]);
            end
            finish_burst(2, dd, a0, a1);
            checks++;
            if ({dd, a0, a1} !== {1'b0, (k != 1), (k == 1)}) begin
                errors++;
                $display("FAIL wr_rr_ack: grant %0d got done/ack0/ack1=%b want %b", k, {dd, a0, a1}, {1'b0, (k != 1), (k == 1)});
            end
        end
    endtask

    task automatic test_disp_priority;
        logic ok, w, dd, a0, a1; logic [21:0] a; logic [1:0] o; int bad;
        iWr0_Level = 10'd200; iWr1_Level = '0;
        wait_cmd(ok, a, w, o);
        $display("txn write addr=%h owner=%0d", a, o);
        checks++;
        if ({ok, a, o} !== {1'b1, 22'h100100, 2'd2}) begin
            errors++; $display("FAIL prio_wr0_cmd: got ok=%0d addr=%h owner=%0d want ok=1 addr=100100 owner=2", ok, a, o);
        end
        iWr0_Level = '0; iWr1_Level = 10'd200;
        pulse_disp(11'd0);
        finish_burst(1, dd, a0, a1);
        checks++;
        if (a0 !== 1'b1) begin errors++; $display("FAIL prio_wr0_ack: got %0d want 1", a0); end
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            wait_cmd(ok, a, w, o);
            if (k == 0) begin
                $display("txn disp addr=%0d owner=%0d", a, o);
                checks++;
                if ({ok, a, w, o} !== {1'b1, 22'd0, 1'b0, 2'd1}) begin
                    errors++; $display("FAIL prio_disp_first: got ok=%0d addr=%0d wr=%0d owner=%0d want ok=1 addr=0 wr=0 owner=1", ok, a, w, o);
                end
            end else if ({ok, a, o} !== {1'b1, 22'(128 * k), 2'd1}) begin
                bad++;
            end
            finish_burst(1, dd, a0, a1);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL prio_disp_rest: got %0d bad bursts want 0", bad); end
        wait_cmd(ok, a, w, o);
        iWr1_Level = '0;
        $display("txn write addr=%h owner=%0d", a, o);
        checks++;
        if ({ok, a, w, o} !== {1'b1, 22'h000080, 1'b1, 2'd3}) begin
            errors++; $display("FAIL prio_wr1_after: got ok=%0d addr=%h wr=%0d owner=%0d want ok=1 addr=000080 wr=1 owner=3", ok, a, w, o);
        end
        finish_burst(1, dd, a0, a1);
    endtask

    task automatic test_underrun;
        logic ok, w, dd, a0, a1; logic [21:0] a; logic [1:0] o; int bad;
        pulse_disp(11'd9);
        for (int k = 0; k < 2; k++) begin
            wait_cmd(ok, a, w, o);
            finish_burst(1, dd, a0, a1);
        end
        wait_cmd(ok, a, w, o);
        $display("txn disp addr=%0d owner=%0d", a, o);
        checks++;
        if ({ok, a} !== {1'b1, 22'd6016}) begin errors++; $display("FAIL urun_third_addr: got ok=%0d addr=%0d want ok=1 addr=6016", ok, a); end
        checks++;
        if (oDisp_Underrun !== 1'b0) begin errors++; $display("FAIL urun_early: got %0d want 0", oDisp_Underrun); end
        pulse_disp(11'd10);
        checks++;
        if (oDisp_Underrun !== 1'b1) begin errors++; $display("FAIL urun_flag: got %0d want 1", oDisp_Underrun); end
        finish_burst(1, dd, a0, a1);
        checks++;
        if (dd !== 1'b0) begin errors++; $display("FAIL urun_stale_done: got %0d want 0", dd); end
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            wait_cmd(ok, a, w, o);
            if (k == 0) begin
                $display("txn disp addr=%0d owner=%0d", a, o);
                checks++;
                if ({ok, a} !== {1'b1, 22'd6400}) begin errors++; $display("FAIL urun_new_addr: got ok=%0d addr=%0d want ok=1 addr=6400", ok, a); end
            end else if ({ok, a} !== {1'b1, 22'(6400 + 128 * k)}) begin
                bad++;
            end
            finish_burst(1, dd, a0, a1);
            if (dd !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL urun_new_line: got %0d bad bursts want 0", bad); end
    endtask

    task automatic test_wr1_wrap;
        logic ok, w, dd, a0, a1; logic [21:0] a; logic [1:0] o; int bad;
        iWr1_Level = 10'd200;
        bad = 0;
        for (int n = 256; n < 307072; n += 128) begin
            wait_cmd(ok, a, w, o);
            if ({ok, a} !== {1'b1, 22'(n)}) begin bad++; break; end
            finish_burst(1, dd, a0, a1);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL wrap_sweep: got addr=%0d ok=%0d at first bad burst want sequential offsets", a, ok); end
        wait_cmd(ok, a, w, o);
        $display("txn write addr=%0d owner=%0d", a, o);
        checks++;
        if ({ok, a, o} !== {1'b1, 22'd307072, 2'd3}) begin errors++; $display("FAIL wrap_last: got ok=%0d addr=%0d owner=%0d want ok=1 addr=307072 owner=3", ok, a, o); end
        finish_burst(1, dd, a0, a1);
        checks++;
        if (a1 !== 1'b1) begin errors++; $display("FAIL wrap_ack: got %0d want 1", a1); end
        wait_cmd(ok, a, w, o);
        $display("txn write addr=%0d owner=%0d", a, o);
        checks++;
        if ({ok, a} !== {1'b1, 22'd0}) begin errors++; $display("FAIL wrap_to_base: got ok=%0d addr=%0d want ok=1 addr=0", ok, a); end
        finish_burst(1, dd, a0, a1);
        wait_cmd(ok, a, w, o);
        checks++;
        if ({ok, a} !== {1'b1, 22'd128}) begin errors++; $display("FAIL fs_pre_addr: got ok=%0d addr=%0d want ok=1 addr=128", ok, a); end
        @(negedge iCLK);
        iWr1_Frame_Start = 1'b1;
        @(negedge iCLK);
        iWr1_Frame_Start = 1'b0;
        finish_burst(1, dd, a0, a1);
        wait_cmd(ok, a, w, o);
        iWr1_Level = '0;
        $display("txn write addr=%0d owner=%0d", a, o);
        checks++;
        if ({ok, a} !== {1'b1, 22'd0}) begin errors++; $display("FAIL fs_restart: got ok=%0d addr=%0d want ok=1 addr=0", ok, a); end
        finish_burst(1, dd, a0, a1);
    endtask

    task automatic test_enable_and_reset;
        logic ok, w, dd, a0, a1; logic [21:0] a; logic [1:0] o; int cnt;
        iEnable = 1'b0; iWr0_Level = 10'd200; iWr1_Level = 10'd200;
        pulse_disp(11'd0);
        count_valid(10, cnt);
        checks++;
        if (cnt !== 0) begin errors++; $display("FAIL enable_gate: got %0d valids want 0", cnt); end
        iEnable = 1'b1; iMem_Cmd_Ready = 1'b0;
        @(negedge iCLK);
        checks++;
        if ({oMem_Cmd_Valid, oOwner, oMem_Addr} !== {1'b1, 2'd1, 22'd0}) begin
            errors++; $display("FAIL enable_latency: got valid=%0d owner=%0d addr=%0d want valid=1 owner=1 addr=0", oMem_Cmd_Valid, oOwner, oMem_Addr);
        end
        @(negedge iCLK);
        checks++;
        if ({oMem_Cmd_Valid, oOwner} !== {1'b1, 2'd1}) begin errors++; $display("FAIL cmd_hold: got valid=%0d owner=%0d want valid=1 owner=1", oMem_Cmd_Valid, oOwner); end
        checks++;
        if (oDisp_Underrun !== 1'b1) begin errors++; $display("FAIL urun_sticky: got %0d want 1", oDisp_Underrun); end
        #2 iRST = 1'b1;
        #1;
        checks++;
        if ({oMem_Cmd_Valid, oMem_Wr, oOwner, oDisp_Burst_Done, oWr0_Ack, oWr1_Ack, oDisp_Underrun, oMem_Addr} !== 30'h0) begin
            errors++; $display("FAIL async_reset: got valid=%0d owner=%0d urun=%0d addr=%0d want all 0", oMem_Cmd_Valid, oOwner, oDisp_Underrun, oMem_Addr);
        end
        @(negedge iCLK);
        iRST = 1'b0; iMem_Cmd_Ready = 1'b1;
        wait_cmd(ok, a, w, o);
        iWr0_Level = '0; iWr1_Level = '0;
        $display("txn write addr=%h owner=%0d", a, o);
        checks++;
        if ({ok, a, w, o} !== {1'b1, 22'h100000, 1'b1, 2'd2}) begin
            errors++; $display("FAIL post_reset_grant: got ok=%0d addr=%h wr=%0d owner=%0d want ok=1 addr=100000 wr=1 owner=2", ok, a, w, o);
        end
        finish_burst(1, dd, a0, a1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_display_line();
        test_write_rr();
        test_disp_priority();
        test_underrun();
        test_wr1_wrap();
        test_enable_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
